// File: rtl/vec_switch_pkg.sv
// ----------------------------------------------------------------------------
// vec_switch_pkg
// Shared types for the vector rendezvous switch: the word and vector types
// carried through the mailboxes and the two-state port handshake enum.
// No ports (package).
// ----------------------------------------------------------------------------
package vec_switch_pkg;

  localparam int SWITCH_WIDTH = 16;  // words per vector
  localparam int WORD_WIDTH   = 32;  // bits per word, opaque to the switch

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef word_t [SWITCH_WIDTH-1:0] vector_t;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } port_state_t;

endpackage

// File: rtl/vec_switch_if.sv
// ----------------------------------------------------------------------------
// vec_switch_if
// Bundles the per-core send/recv switch ports. Every signal is an unpacked
// array indexed by core number.
//   master : core side  (drives send_ready/idx/data, recv_request/idx)
//   slave  : switch side (drives send_ok, recv_ready, recv_data)
// ----------------------------------------------------------------------------
interface vec_switch_if #(
  parameter int SWITCH_CORE_SIZE      = 4,
  parameter int SWITCH_CORE_ADDR_SIZE = (SWITCH_CORE_SIZE > 1) ? $clog2(SWITCH_CORE_SIZE) : 1
);
  import vec_switch_pkg::*;

  logic                             switch_send_ready    [SWITCH_CORE_SIZE];
  logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_send_core_idx [SWITCH_CORE_SIZE];
  vector_t                          switch_send_data     [SWITCH_CORE_SIZE];
  logic                             switch_send_ok       [SWITCH_CORE_SIZE];
  logic                             switch_recv_request  [SWITCH_CORE_SIZE];
  logic [SWITCH_CORE_ADDR_SIZE-1:0] switch_recv_core_idx [SWITCH_CORE_SIZE];
  logic                             switch_recv_ready    [SWITCH_CORE_SIZE];
  vector_t                          switch_recv_data     [SWITCH_CORE_SIZE];

  modport master (
    output switch_send_ready, switch_send_core_idx, switch_send_data,
    output switch_recv_request, switch_recv_core_idx,
    input  switch_send_ok, switch_recv_ready, switch_recv_data
  );

  modport slave (
    input  switch_send_ready, switch_send_core_idx, switch_send_data,
    input  switch_recv_request, switch_recv_core_idx,
    output switch_send_ok, switch_recv_ready, switch_recv_data
  );

endinterface

// File: rtl/vec_switch_mailbox.sv
// ----------------------------------------------------------------------------
// vec_switch_mailbox
// One-entry mailbox for a single (source, destination) pair.
//   clock, reset  : clock and asynchronous active-low reset
//   i_wr_en       : store i_data (ignored while the slot is full)
//   i_rd_en       : consume the stored vector (clears valid)
//   i_data        : vector to store
//   o_data        : stored vector
//   o_valid       : slot holds an unconsumed vector
// A read and a write in the same cycle both act on the old state, so a full
// slot being drained cannot be refilled until the following cycle.
// ----------------------------------------------------------------------------
module vec_switch_mailbox
  import vec_switch_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    i_wr_en,
  input  logic    i_rd_en,
  input  vector_t i_data,
  output vector_t o_data,
  output logic    o_valid
);

  logic    r_valid;
  vector_t r_data;
  logic    w_wr_accept;

  assign w_wr_accept = i_wr_en && !r_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
    end else if (i_rd_en && r_valid) begin
      r_valid <= 1'b0;
    end else if (w_wr_accept) begin
      r_valid <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed while r_valid is set.
  always_ff @(posedge clock) begin
    if (w_wr_accept) begin
      r_data <= i_data;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/vec_switch.sv
// ----------------------------------------------------------------------------
// vec_switch
// Rendezvous switch between SWITCH_CORE_SIZE vector cores. Each (src, dst)
// pair owns a one-entry mailbox, so every slot has exactly one writer and one
// reader and no arbitration is required.
//   clock, reset : clock and asynchronous active-low reset
//   bus          : per-core send/recv ports (vec_switch_if.slave)
// Each send port and each recv port runs an IDLE/ACK handshake: a request is
// taken in IDLE, the one-cycle acknowledge is shown in ACK, and the port's
// request input is ignored while in ACK. Out-of-range core indices never match
// a mailbox and therefore stall silently.
// ----------------------------------------------------------------------------
module vec_switch
  import vec_switch_pkg::*;
#(
  parameter int SWITCH_CORE_SIZE = 4
) (
  input  logic         clock,
  input  logic         reset,
  vec_switch_if.slave  bus
);

  localparam int N = SWITCH_CORE_SIZE;

  logic        w_mb_wr    [N][N];
  logic        w_mb_rd    [N][N];
  logic        w_mb_valid [N][N];
  vector_t     w_mb_data  [N][N];

  port_state_t r_send_state     [N];
  port_state_t w_send_state_nxt [N];
  port_state_t r_recv_state     [N];
  port_state_t w_recv_state_nxt [N];
  logic        w_recv_go        [N];
  vector_t     w_recv_sel       [N];
  vector_t     r_recv_data      [N];

  for (genvar gs = 0; gs < N; gs++) begin : g_src
    for (genvar gd = 0; gd < N; gd++) begin : g_dst
      vec_switch_mailbox u_mbox (
        .clock   (clock),
        .reset   (reset),
        .i_wr_en (w_mb_wr[gs][gd]),
        .i_rd_en (w_mb_rd[gs][gd]),
        .i_data  (bus.switch_send_data[gs]),
        .o_data  (w_mb_data[gs][gd]),
        .o_valid (w_mb_valid[gs][gd])
      );
    end
  end

  // Send side: decode destination, accept only into an empty slot.
  always_comb begin
    for (int s = 0; s < N; s++) begin
      w_send_state_nxt[s] = IDLE;
      for (int d = 0; d < N; d++) begin
        w_mb_wr[s][d] = 1'b0;
      end
      if (r_send_state[s] == IDLE && bus.switch_send_ready[s]) begin
        for (int d = 0; d < N; d++) begin
          if (int'(bus.switch_send_core_idx[s]) == d && !w_mb_valid[s][d]) begin
            w_mb_wr[s][d]       = 1'b1;
            w_send_state_nxt[s] = ACK;
          end
        end
      end
    end
  end

  // Recv side: decode source, consume only a full slot. Validity is the
  // registered state, so a vector written this cycle is not bypassed.
  always_comb begin
    for (int d = 0; d < N; d++) begin
      w_recv_state_nxt[d] = IDLE;
      w_recv_go[d]        = 1'b0;
      w_recv_sel[d]       = '0;
      for (int s = 0; s < N; s++) begin
        w_mb_rd[s][d] = 1'b0;
      end
      if (r_recv_state[d] == IDLE && bus.switch_recv_request[d]) begin
        for (int s = 0; s < N; s++) begin
          if (int'(bus.switch_recv_core_idx[d]) == s && w_mb_valid[s][d]) begin
            w_mb_rd[s][d]       = 1'b1;
            w_recv_go[d]        = 1'b1;
            w_recv_sel[d]       = w_mb_data[s][d];
            w_recv_state_nxt[d] = ACK;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < N; n++) begin
        r_send_state[n] <= IDLE;
        r_recv_state[n] <= IDLE;
        r_recv_data[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < N; n++) begin
        r_send_state[n] <= w_send_state_nxt[n];
        r_recv_state[n] <= w_recv_state_nxt[n];
        if (w_recv_go[n]) begin
          r_recv_data[n] <= w_recv_sel[n];
        end
      end
    end
  end

  // Acknowledges are decoded from state so an async reset drops them at once.
  for (genvar gc = 0; gc < N; gc++) begin : g_out
    assign bus.switch_send_ok[gc]    = (r_send_state[gc] == ACK);
    assign bus.switch_recv_ready[gc] = (r_recv_state[gc] == ACK);
    assign bus.switch_recv_data[gc]  = r_recv_data[gc];
  end

endmodule

// File: doc/vec_switch.md
# vec_switch

Rendezvous switch that sits between SWITCH_CORE_SIZE vector cores and acts as the responder for each core's send/recv switch ports. Every (source, destination) pair has a one-entry mailbox holding one SWITCH_WIDTH-word vector. The switch acknowledges a core's send once the vector is stored. It answers a core's recv once a vector from the requested source is available.

## Interface
- SWITCH_CORE_SIZE, 4: number of attached cores
- SWITCH_WIDTH, 16: words per vector
- WORD_WIDTH, 32: bits per word (IEEE-754 single, opaque to the switch)
- SWITCH_CORE_ADDR_SIZE, $clog2(SWITCH_CORE_SIZE): core index width (derived)

All per-core ports are unpacked arrays indexed by core number c.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- switch_send_ready[c]  in  1  core c presents a vector to send
- switch_send_core_idx[c]  in  ADDR  destination core of the send
- switch_send_data[c][SWITCH_WIDTH]  in  WORD_WIDTH each  vector to send
- switch_send_ok[c]  out  1  one-cycle pulse: send accepted
- switch_recv_request[c]  in  1  core c requests a vector
- switch_recv_core_idx[c]  in  ADDR  source core it wants to receive from
- switch_recv_ready[c]  out  1  one-cycle pulse: switch_recv_data valid
- switch_recv_data[c][SWITCH_WIDTH]  out  WORD_WIDTH each  received vector

## Operation
- Storage: mailbox[s][d] = valid bit + SWITCH_WIDTH words, for all s,d (self-send s==d allowed).
- Send FSM per source core s: states IDLE, ACK.
  - IDLE: if send_ready[s], send_core_idx[s] < SWITCH_CORE_SIZE, and mailbox[s][d] is not valid at the start of the cycle: latch data, set valid, go to ACK.
  - Otherwise stay in IDLE (stall). The core holds its inputs stable.
  - ACK: send_ok[s]=1 and send_ready[s] is ignored. Return to IDLE next cycle.
- Recv FSM per destination core d: states IDLE, ACK.
  - IDLE: if recv_request[d], s=recv_core_idx[d] in range, and mailbox[s][d] valid: register its data into recv_data[d], clear valid, go to ACK.
  - ACK: recv_ready[d]=1 with data valid and recv_request[d] is ignored. Return to IDLE.
- Out-of-range index: the request is never served and no error is raised.
- recv_data[d] holds its last value until the next recv for d.
- Ordering: per (s,d), vectors are delivered in send order. Depth 1 enforces this.
- No arbitration is needed. Each mailbox has exactly one writer (s) and one reader (d).

## Timing
- Reset (reset=0, async): all mailboxes invalid, all FSMs IDLE, send_ok=0, recv_ready=0, recv_data=0.
- Send latency: request sampled at edge N into an empty slot → send_ok high during cycle N+1 → low at N+2.
- Recv latency: request sampled at edge N with a valid slot → recv_ready and data in cycle N+1.
- Send into an empty slot and recv of that slot in the same cycle: the recv sees empty (no bypass). The recv is served one cycle later, so minimum send-to-recv_ready is 2 cycles.
- Send to a full slot that is being drained the same cycle: the send sees full and is accepted next cycle.
- Minimum back-to-back rate per port is one transfer per 2 cycles (IDLE/ACK).
- Reset asserted mid-operation: in-flight ACK pulses are dropped and stored vectors are discarded.

## Structure
- Package vec_switch_pkg holds:
  - word_t (logic [WORD_WIDTH-1:0])
  - vector_t (word_t array [SWITCH_WIDTH])
  - enum port_state_t {IDLE, ACK}
- Sub-module vec_switch_mailbox: one slot with write-enable, read-enable, data in/out and valid.
  - Instantiated SWITCH_CORE_SIZE² times in a generate loop.
  - Simultaneous wr/rd: rd wins on the old state; wr is blocked when valid.
- The top holds the per-port FSMs and the index decode/mux.

## Test plan
- Basic transfer: core0 sends V=[1.0..16.0] to core2, core2 recv from 0 → send_ok[0] at cycle 1, recv_ready[2] at cycle 1 after request, data == V bitwise.
- Full stall: core1 sends A then B to core3 with no recv → B gets no send_ok. Core3 recv from 1 → gets A. B is then accepted and the next recv returns B.
- Recv before send: core3 requests from core0 for 5 cycles → no recv_ready. Core0 sends X → recv_ready[3] exactly 2 cycles after the send is sampled, data == X.
- Concurrent: all 4 cores send to (c+1)%4 and recv from (c+3)%4 in the same cycle → every port completes one send_ok and one recv_ready with the correct vector. No cross-talk.
- Self-send plus out-of-range: core0 sends to 0 and receives its own vector. With SWITCH_CORE_SIZE=3, a send to index 3 never gets send_ok and other ports are unaffected.
- Async reset mid-transfer: fill mailbox[0][1], then pull reset low between edges → outputs 0 immediately. After release, recv from 0 by core1 stalls (mailbox empty).
